// File: rtl/spi_shift_core.sv
// Master-mode SPI shift engine with baud generator, SS control and mode-fault detection.
// Optional build macro SPI_LOOPBACK_EN adds loopback_in (internal MOSI->sample path).
module spi_shift_core #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  apb_clk_in,
  input  logic                  apb_rst_in,
  input  logic                  spe_in,
  input  logic                  cpol_in,
  input  logic                  cpha_in,
  input  logic                  lsbfe_in,
  input  logic                  ssoe_in,
  input  logic                  modfen_in,
  input  logic [2:0]            sppr_in,
  input  logic [2:0]            spr_in,
  input  logic                  start_in,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
`ifdef SPI_LOOPBACK_EN
  input  logic                  loopback_in,
`endif
  input  logic                  miso_in,
  input  logic                  ss_in,
  output logic                  mosi_out,
  output logic                  sck_out,
  output logic                  ss_out,
  output logic                  ss_oe_out,
  output logic                  busy_out,
  output logic [DATA_WIDTH-1:0] shift_reg_out,
  output logic                  shift_finish_out,
  output logic                  modf_out
);

  localparam int EW = $clog2(2*DATA_WIDTH+1);
  localparam logic [EW-1:0] LAST_EDGE   = EW'(2*DATA_WIDTH);
  localparam logic [EW-1:0] FINAL_SHIFT = EW'(2*DATA_WIDTH-1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_tx(input logic [DATA_WIDTH-1:0] d, input logic lsb);
    return lsb ? {1'b0, d[DATA_WIDTH-1:1]} : {d[DATA_WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_rx(input logic [DATA_WIDTH-1:0] d, input logic b,
                                                     input logic lsb);
    return lsb ? {b, d[DATA_WIDTH-1:1]} : {d[DATA_WIDTH-2:0], b};
  endfunction

  state_t                  state_r, state_s;
  logic [10:0]             hcnt_r, hcnt_s, half_r, half_s, half_in_s;
  logic [EW-1:0]           ecnt_r, ecnt_s;
  logic                    tog_r, tog_s, cpol_r, cpol_s, cpha_r, cpha_s, lsbfe_r, lsbfe_s;
  logic [DATA_WIDTH-1:0]   tx_sr_r, tx_sr_s, rx_sr_r, rx_sr_s, shreg_r, shreg_s;
  logic                    mosi_r, mosi_s, ss_r, ss_s, busy_r, busy_s;
  logic                    fin_r, fin_s, modf_r, modf_s, fault_prev_r;
  logic [SYNC_STAGES-1:0]  miso_sync_r, ss_sync_r;
  logic                    fault_s, abort_s, hend_s, edge_s, odd_s, do_shift_s, do_sample_s;
  logic                    sample_bit_s;

  assign half_in_s  = ({8'd0, sppr_in} + 11'd1) << spr_in;
  assign fault_s    = modfen_in & ~ssoe_in & spe_in & ~ss_sync_r[SYNC_STAGES-1];
  assign abort_s    = fault_s | ~spe_in;
  assign hend_s     = (hcnt_r == (half_r - 11'd1));
  assign edge_s     = hend_s & (ecnt_r != LAST_EDGE);
  // ecnt_r holds the number of edges already taken, so an even count means the next edge is odd.
  assign odd_s      = ~ecnt_r[0];
  assign do_shift_s  = edge_s & (cpha_r ? odd_s : (~odd_s & (ecnt_r != FINAL_SHIFT)));
  assign do_sample_s = edge_s & (cpha_r ? ~odd_s : odd_s);

`ifdef SPI_LOOPBACK_EN
  logic loop_r, loop_s;
  assign sample_bit_s = loop_r ? mosi_r : miso_sync_r[SYNC_STAGES-1];
`else
  assign sample_bit_s = miso_sync_r[SYNC_STAGES-1];
`endif

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    state_s = state_r;   hcnt_s  = hcnt_r;  half_s  = half_r;  ecnt_s = ecnt_r;
    tog_s   = tog_r;     cpol_s  = cpol_r;  cpha_s  = cpha_r;  lsbfe_s = lsbfe_r;
    tx_sr_s = tx_sr_r;   rx_sr_s = rx_sr_r; shreg_s = shreg_r;
    mosi_s  = mosi_r;    ss_s    = ss_r;    busy_s  = busy_r;
    fin_s   = 1'b0;
    modf_s  = fault_s & ~fault_prev_r;
`ifdef SPI_LOOPBACK_EN
    loop_s  = loop_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start_in && spe_in && !fault_s) begin
          state_s = ST_RUN;  hcnt_s = 11'd0;  half_s = half_in_s;  ecnt_s = '0;
          tog_s   = 1'b0;    cpol_s = cpol_in; cpha_s = cpha_in;   lsbfe_s = lsbfe_in;
          rx_sr_s = '0;      busy_s = 1'b1;   ss_s   = 1'b0;
`ifdef SPI_LOOPBACK_EN
          loop_s  = loopback_in;
`endif
          if (!cpha_in) begin
            mosi_s  = first_bit(tx_data_in, lsbfe_in);
            tx_sr_s = shift_tx(tx_data_in, lsbfe_in);
          end else begin
            tx_sr_s = tx_data_in;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          state_s = ST_IDLE; busy_s = 1'b0; ss_s = 1'b1; mosi_s = 1'b1;
          tog_s   = 1'b0;    hcnt_s = 11'd0; ecnt_s = '0;
        end else if (hend_s) begin
          hcnt_s = 11'd0;
          if (ecnt_r == LAST_EDGE) begin
            state_s = ST_DONE;
          end else begin
            ecnt_s = ecnt_r + EW'(1);
            tog_s  = ~tog_r;
            if (do_shift_s) begin
              mosi_s  = first_bit(tx_sr_r, lsbfe_r);
              tx_sr_s = shift_tx(tx_sr_r, lsbfe_r);
            end else begin
              tx_sr_s = tx_sr_r;
            end
            if (do_sample_s) begin
              rx_sr_s = shift_rx(rx_sr_r, sample_bit_s, lsbfe_r);
            end else begin
              rx_sr_s = rx_sr_r;
            end
          end
        end else begin
          hcnt_s = hcnt_r + 11'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE; busy_s = 1'b0; ss_s = 1'b1; mosi_s = 1'b1;
        tog_s   = 1'b0;    hcnt_s = 11'd0; ecnt_s = '0;
        if (abort_s) begin
          fin_s = 1'b0;
        end else begin
          fin_s   = 1'b1;
          shreg_s = rx_sr_r;
        end
      end
      default: begin
        state_s = ST_IDLE; busy_s = 1'b0; ss_s = 1'b1; mosi_s = 1'b1;
        tog_s   = 1'b0;    hcnt_s = 11'd0; ecnt_s = '0;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge apb_clk_in) begin
    if (apb_rst_in) begin
      state_r <= ST_IDLE;  hcnt_r <= 11'd0;  half_r <= 11'd1;  ecnt_r <= '0;
      tog_r   <= 1'b0;     cpol_r <= 1'b0;   cpha_r <= 1'b0;   lsbfe_r <= 1'b0;
      tx_sr_r <= '0;       rx_sr_r <= '0;    shreg_r <= '0;
      mosi_r  <= 1'b1;     ss_r   <= 1'b1;   busy_r <= 1'b0;
      fin_r   <= 1'b0;     modf_r <= 1'b0;   fault_prev_r <= 1'b0;
`ifdef SPI_LOOPBACK_EN
      loop_r  <= 1'b0;
`endif
    end else begin
      state_r <= state_s;  hcnt_r <= hcnt_s; half_r <= half_s; ecnt_r <= ecnt_s;
      tog_r   <= tog_s;    cpol_r <= cpol_s; cpha_r <= cpha_s; lsbfe_r <= lsbfe_s;
      tx_sr_r <= tx_sr_s;  rx_sr_r <= rx_sr_s; shreg_r <= shreg_s;
      mosi_r  <= mosi_s;   ss_r   <= ss_s;   busy_r <= busy_s;
      fin_r   <= fin_s;    modf_r <= modf_s; fault_prev_r <= fault_s;
`ifdef SPI_LOOPBACK_EN
      loop_r  <= loop_s;
`endif
    end
  end

  // Metastability synchronizers for the asynchronous MISO and SS pins.
  always_ff @(posedge apb_clk_in) begin
    if (apb_rst_in) begin
      miso_sync_r <= '1;
      ss_sync_r   <= '1;
    end else begin
      miso_sync_r <= {miso_sync_r[SYNC_STAGES-2:0], miso_in};
      ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], ss_in};
    end
  end

  assign mosi_out         = mosi_r;
  assign sck_out          = (state_r == ST_IDLE) ? cpol_in : (cpol_r ^ tog_r);
  assign ss_out           = ss_r;
  assign ss_oe_out        = spe_in & modfen_in & ssoe_in;
  assign busy_out         = busy_r;
  assign shift_reg_out    = shreg_r;
  assign shift_finish_out = fin_r;
  assign modf_out         = modf_r;

endmodule
